// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl_pkg
// Description : Shared state and halt-cause encodings for the run-control
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

    localparam logic [1:0] c_st_reset = 2'd0;
    localparam logic [1:0] c_st_halt  = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;
    localparam logic [1:0] c_st_step  = 2'd3;

    localparam logic [1:0] c_cause_none = 2'd0;
    localparam logic [1:0] c_cause_cmd  = 2'd1;
    localparam logic [1:0] c_cause_bp   = 2'd2;
    localparam logic [1:0] c_cause_op   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/run_ctrl_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sat_cnt
// Description : Up-counter that sticks at all-ones; clear wins over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out = r_cnt;

endmodule
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl
// Description : Run-control sequencer (reset / halt / step / run) producing
//               the core-wide enable and core reset.
// Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               CNT_WIDTH   = 16,
    parameter int               RST_CYCLES  = 2,
    parameter logic [WIDTH-1:0] HALT_OPCODE = {WIDTH{1'b1}},
    parameter bit               AUTO_RUN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_run,
    input  logic                 cmd_halt,
    input  logic                 cmd_step,
    input  logic                 cmd_reset,
    input  logic                 bp_en,
    input  logic [WIDTH-1:0]     bp_addr,
    input  logic [WIDTH-1:0]     pc,
    input  logic [WIDTH-1:0]     instr,
    output logic                 cpu_en,
    output logic                 cpu_rst,
    output logic [1:0]           state,
    output logic [1:0]           halt_cause,
    output logic                 step_done,
    output logic [CNT_WIDTH-1:0] instr_cnt
);

    localparam int c_RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_RST_W-1:0] c_rst_last = c_RST_W'(RST_CYCLES - 1);

    logic [1:0]         r_state;
    logic [1:0]         r_halt_cause;
    logic               r_skip_bp;
    logic               r_step_done;
    logic [c_RST_W-1:0] r_rst_cnt;

    logic [1:0] w_next;
    logic [1:0] w_cause_next;
    logic       w_skip_next;
    logic       w_step_done_next;
    logic       w_cpu_en;
    logic       w_bp_hit;
    logic       w_halt_op;
    logic       w_stop;
    logic       w_rst_restart;

    assign w_bp_hit  = bp_en && (pc == bp_addr) && !r_skip_bp;
    assign w_halt_op = (instr == HALT_OPCODE);
    assign w_stop    = cmd_reset || cmd_halt || w_bp_hit || w_halt_op;

    always_comb begin
        w_next           = r_state;
        w_cause_next     = r_halt_cause;
        w_skip_next      = r_skip_bp;
        w_step_done_next = 1'b0;
        w_cpu_en         = 1'b0;
        case (r_state)
            c_st_reset: begin
                if (!cmd_reset && (r_rst_cnt == c_rst_last)) begin
                    w_next = AUTO_RUN ? c_st_run : c_st_halt;
                end
            end
            c_st_halt: begin
                if (cmd_reset) begin
                    w_next = c_st_reset;
                end else if (cmd_halt) begin
                    w_next = c_st_halt;
                end else if (cmd_step) begin
                    w_next      = c_st_step;
                    w_skip_next = 1'b1;
                end else if (cmd_run) begin
                    w_next      = c_st_run;
                    w_skip_next = 1'b1;
                end
            end
            c_st_run: begin
                // Stop is combinational so a stopping instruction never executes
                w_cpu_en = !w_stop;
                if (cmd_reset) begin
                    w_next = c_st_reset;
                end else if (w_stop) begin
                    w_next       = c_st_halt;
                    w_cause_next = cmd_halt ? c_cause_cmd :
                                   w_bp_hit ? c_cause_bp  : c_cause_op;
                end
            end
            c_st_step: begin
                w_cpu_en = !w_halt_op;
                if (w_halt_op) begin
                    w_cause_next = c_cause_op;
                end
                if (cmd_reset) begin
                    w_next = c_st_reset;
                end else begin
                    w_next           = c_st_halt;
                    w_step_done_next = 1'b1;
                end
            end
            default: begin
                w_next = c_st_reset;
            end
        endcase
        if (w_cpu_en) begin
            w_skip_next = 1'b0;
        end
        if (w_next == c_st_reset) begin
            w_cause_next = c_cause_none;
            w_skip_next  = 1'b0;
        end
    end

    // Reset-length counter restarts on every entry into RESET and on cmd_reset
    assign w_rst_restart = (w_next == c_st_reset) && ((r_state != c_st_reset) || cmd_reset);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_reset;
            r_halt_cause <= c_cause_none;
            r_skip_bp    <= 1'b0;
            r_step_done  <= 1'b0;
            r_rst_cnt    <= '0;
        end else begin
            r_state      <= w_next;
            r_halt_cause <= w_cause_next;
            r_skip_bp    <= w_skip_next;
            r_step_done  <= w_step_done_next;
            if (w_rst_restart) begin
                r_rst_cnt <= '0;
            end else if (r_state == c_st_reset) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end
        end
    end

    sat_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_instr_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_next == c_st_reset),
        .inc (w_cpu_en),
        .out (instr_cnt)
    );

    assign cpu_en     = w_cpu_en;
    assign cpu_rst    = (r_state == c_st_reset);
    assign state      = r_state;
    assign halt_cause = r_halt_cause;
    assign step_done  = r_step_done;

endmodule
`default_nettype wire
